// File: rtl/tile_stream_unpacker.sv
// Captures loader tiles into a small FIFO and streams them out as LANES-wide
// beats, trimmed to the requested element count, with last/done signalling.
module tile_stream_unpacker #(
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [19:0]                      length,
  input  logic [TILE_WIDTH-1:0]            tile_in,
  input  logic                             tile_valid,
  output logic                             tile_ready,
  output logic [LANES*DATA_WIDTH-1:0]      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [$clog2(LANES+1)-1:0]       out_count,
  output logic                             done,
  output logic                             overflow
);

  localparam int unsigned BEAT_BITS = LANES * DATA_WIDTH;
  localparam int unsigned BEATS     = TILE_WIDTH / BEAT_BITS;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LEN_W     = 20;
  localparam int unsigned OCNT_W    = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [TILE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [TILE_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic                  flush_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  hs_c;
  logic [TILE_WIDTH-1:0] head_c;
  logic [BEATS-1:0][LANES-1:0][DATA_WIDTH-1:0] beat_view_c;
  logic [LANES-1:0][DATA_WIDTH-1:0]            cur_beat_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Beat view of the head tile: element 0 sits at the tile MSB.
  assign head_c = mem_q[rd_ptr_q];
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign beat_view_c[b][l] =
        head_c[TILE_WIDTH-1-(b*LANES+l)*DATA_WIDTH -: DATA_WIDTH];
    end
  end
  assign cur_beat_c = beat_view_c[beat_idx_q];

  assign out_valid  = (state_q == S_RUN) && (count_q != '0);
  assign out_count  = !out_valid ? '0 :
                      (rem_q < LEN_W'(LANES)) ? OCNT_W'(rem_q) : OCNT_W'(LANES);
  assign out_last   = out_valid && (rem_q <= LEN_W'(LANES));
  assign hs_c       = out_valid && out_ready;
  assign tile_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign done       = done_q;
  assign overflow   = overflow_q;

  // Lanes past the remaining element count are zeroed.
  for (genvar i = 0; i < LANES; i++) begin : g_out
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (out_valid && (rem_q > LEN_W'(i))) ? cur_beat_c[i] : '0;
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    beat_idx_d = beat_idx_q;
    overflow_d = overflow_q;
    flush_c    = 1'b0;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d      = length;
          beat_idx_d = '0;
          overflow_d = 1'b0;
          flush_c    = 1'b1;
          state_d    = (length != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (hs_c) begin
          rem_d = rem_q - LEN_W'(out_count);
          if (out_last) begin
            pop_c      = 1'b1;
            beat_idx_d = '0;
            state_d    = S_DONE;
          end else if (beat_idx_q == BEAT_W'(BEATS - 1)) begin
            pop_c      = 1'b1;
            beat_idx_d = '0;
          end else begin
            beat_idx_d = beat_idx_q + BEAT_W'(1);
          end
        end
      end
      S_DONE: begin
        flush_c = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);

    // A tile arriving alongside a flush survives as the new first entry.
    if (flush_c) begin
      rd_ptr_d = '0;
      if (tile_valid) begin
        mem_d[0] = tile_in;
        wr_ptr_d = ptr_inc('0);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end else begin
      push_c = tile_valid && ((count_q < CNT_W'(FIFO_DEPTH)) || pop_c);
      if (pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_c) begin
        mem_d[wr_ptr_q] = tile_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (tile_valid && !push_c) begin
        overflow_d = 1'b1;
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      beat_idx_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      beat_idx_q <= beat_idx_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Tile storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_tile_stream_unpacker.sv
// Randomized bench for tile_stream_unpacker against a queue-based element model.
module tb_tile_stream_unpacker;

  localparam int unsigned TW    = 256;
  localparam int unsigned DW    = 8;
  localparam int unsigned LN    = 4;
  localparam int unsigned FD    = 2;
  localparam int unsigned ELEMS = TW / DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [19:0]   length;
  logic [TW-1:0] tile_in;
  logic          tile_valid;
  logic          tile_ready;
  logic [LN*DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [2:0]    out_count;
  logic          done;
  logic          overflow;

  tile_stream_unpacker #(
    .TILE_WIDTH(TW), .DATA_WIDTH(DW), .LANES(LN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .tile_in(tile_in), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_count(out_count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tile queue plus element progress through the transfer.
  logic [TW-1:0] mq[$];
  int unsigned   m_rem;
  int unsigned   m_cons;
  bit            m_run;
  bit            m_done;
  bit            m_ovf;
  int            rmode;
  bit            tog;

  function automatic logic [DW-1:0] elem(input logic [TW-1:0] t, input int unsigned e);
    return DW'(t >> (DW * (ELEMS - 1 - e)));
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int w = 0; w < TW / 32; w++) t[w*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rem = 0; m_cons = 0; m_run = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    int unsigned cnt;
    logic [LN*DW-1:0] ed;
    ev = m_run && (mq.size() > 0);
    chk("out_valid", out_valid, ev);
    chk("tile_ready", tile_ready, mq.size() < FD);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    if (ev) begin
      cnt = (m_rem < LN) ? m_rem : LN;
      ed  = '0;
      for (int i = 0; i < int'(cnt); i++)
        ed[i*DW +: DW] = elem(mq[0], (m_cons % ELEMS) + i);
      chk("out_data", out_data, ed);
      chk("out_count", out_count, cnt);
      chk("out_last", out_last, m_rem <= LN);
    end
  endtask

  task automatic model_update();
    bit ev, flush, pop, nd;
    int unsigned c;
    ev = m_run && (mq.size() > 0);
    flush = 0; pop = 0; nd = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_done) begin
      flush = 1;
    end else if (!m_run && start) begin
      m_rem = length; m_cons = 0; m_ovf = 0; flush = 1;
      if (length == 0) nd = 1; else m_run = 1;
    end else if (ev && out_ready) begin
      c = (m_rem < LN) ? m_rem : LN;
      m_rem  -= c;
      m_cons += c;
      if (m_rem == 0) begin
        pop = 1; m_run = 0; nd = 1;
      end else if (m_cons % ELEMS == 0) begin
        pop = 1;
      end
    end
    if (flush) begin
      mq.delete();
      if (tile_valid) mq.push_back(tile_in);
    end else begin
      if (pop) void'(mq.pop_front());
      if (tile_valid) begin
        if (mq.size() < FD) mq.push_back(tile_in);
        else m_ovf = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic set_ready();
    tog = ~tog;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = tog;
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    start      = 1'b0;
    tile_valid = 1'b0;
    set_ready();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [TW-1:0] t);
    tile_valid = 1'b1;
    tile_in    = t;
    cycle();
  endtask

  task automatic go(input int unsigned len);
    start  = 1'b1;
    length = 20'(len);
  endtask

  logic [TW-1:0] ctile;

  initial begin
    rst = 1'b1; start = 1'b0; length = '0; tile_in = '0; tile_valid = 1'b0;
    out_ready = 1'b1; rmode = 0; tog = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    run(2);

    // Counting tile, full-rate consumer
    for (int k = 0; k < int'(ELEMS); k++) ctile[TW-1-DW*k -: DW] = DW'(k);
    go(32); cycle();
    send(ctile);
    chk("beat0_data", out_data, 32'h03020100);
    run(12);

    // Short transfer with start and tile in the same cycle
    go(10); tile_valid = 1'b1; tile_in = rand_tile(); cycle();
    run(6);

    // Two tiles, toggling consumer
    rmode = 1;
    go(64); cycle();
    send(rand_tile());
    run(33);
    send(rand_tile());
    run(24);

    // Stalled consumer: third tile overflows
    rmode = 3; set_ready();
    go(96); cycle();
    send(rand_tile());
    send(rand_tile());
    chk("full_tile_ready", tile_ready, 1'b0);
    send(rand_tile());
    chk("overflow_set", overflow, 1'b1);
    run(5);
    rmode = 0;
    run(20);
    send(rand_tile());
    run(12);

    // Zero length, stale tile flushed by next start
    go(0); cycle();
    run(3);
    send(rand_tile());
    run(2);
    go(8); cycle();
    run(2);
    send(rand_tile());
    run(6);

    // Reset mid-stream then a one-beat transfer
    go(32); cycle();
    send(rand_tile());
    run(3);
    rst = 1'b1; cycle();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    go(4); tile_valid = 1'b1; tile_in = rand_tile(); cycle();
    run(4);

    // Random transfers
    rmode = 2;
    for (int x = 0; x < 25; x++) begin
      int unsigned len, needed, sent, budget;
      len = $urandom_range(0, 100);
      go(len); cycle();
      needed = (len + ELEMS - 1) / ELEMS + $urandom_range(0, 1);
      sent = 0; budget = 0;
      while ((m_run || m_done) && budget < 600) begin
        if (sent < needed && mq.size() < FD && $urandom_range(0, 2) == 0) begin
          tile_valid = 1'b1;
          tile_in    = rand_tile();
          sent++;
        end
        cycle();
        budget++;
      end
      if (budget >= 600) chk("xfer_timeout", budget, 0);
      run($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
